// File: rtl/adc_chirp_capture_pkg.sv
// Shared definitions for the chirp-aligned ADC capture block.
// State encodings, default widths and the FIFO payload width.
`timescale 1ns/1ps
package adc_cap_pkg;

    localparam int ADC_WIDTH_DEF    = 12;
    localparam int SAMPLE_IDX_W_DEF = 10;
    localparam int CHIRP_IDX_W_DEF  = 5;
    localparam int SKIP_W_DEF       = 8;

    // Output word: {sample, sample index, chirp index, last flag}
    localparam int PAYLOAD_W_DEF = ADC_WIDTH_DEF + SAMPLE_IDX_W_DEF + CHIRP_IDX_W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_CHIRP = 3'd1,
        SKIP       = 3'd2,
        CAPTURE    = 3'd3,
        FRAME_DONE = 3'd4
    } cap_state_e;

endpackage

// File: rtl/adc_chirp_capture_fifo.sv
// Two-entry synchronous FIFO holding tagged samples for the range-FFT stage.
// A push while full is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module sample_fifo_2
    import adc_cap_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == 2'd0);
    assign full_o  = (count == 2'd2);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_chirp_capture.sv
// Captures beat-signal ADC samples aligned to each TX chirp: drops settling
// samples, frames N samples x M chirps and emits a tagged stream.
`timescale 1ns/1ps
module adc_chirp_capture
    import adc_cap_pkg::*;
#(
    parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
    parameter int SAMPLE_IDX_W = SAMPLE_IDX_W_DEF,
    parameter int CHIRP_IDX_W  = CHIRP_IDX_W_DEF,
    parameter int SKIP_W       = SKIP_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    chirp_start_i,
    input  logic [ADC_WIDTH-1:0]    adc_data_i,
    input  logic                    adc_valid_i,
    input  logic [SAMPLE_IDX_W-1:0] samples_per_chirp_i,
    input  logic [CHIRP_IDX_W-1:0]  chirp_num_i,
    input  logic [SKIP_W-1:0]       skip_samples_i,
    input  logic                    clear_flags_i,
    input  logic                    sample_ready_i,
    output logic [ADC_WIDTH-1:0]    sample_o,
    output logic                    sample_valid_o,
    output logic [SAMPLE_IDX_W-1:0] sample_idx_o,
    output logic [CHIRP_IDX_W-1:0]  chirp_idx_o,
    output logic                    last_sample_o,
    output logic                    frame_done_o,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic                    chirp_err_o,
    output logic                    cfg_err_o
);

    localparam int PAYLOAD_W = ADC_WIDTH + SAMPLE_IDX_W + CHIRP_IDX_W + 1;

    cap_state_e state, state_nxt;

    logic [SAMPLE_IDX_W-1:0] cfg_n, sample_cnt, sample_cnt_nxt;
    logic [CHIRP_IDX_W-1:0]  cfg_m, chirp_cnt, chirp_cnt_nxt;
    logic [SKIP_W-1:0]       cfg_skip, skip_cnt, skip_cnt_nxt;

    logic           cfg_ok;
    logic           latch_cfg;
    logic           push;
    logic           last_flag;
    logic           flush;
    logic           set_cfg_err;
    logic           set_chirp_err;
    logic           set_overrun;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    cap_state_e     restart_state;
    logic [PAYLOAD_W-1:0] push_word;
    logic [PAYLOAD_W-1:0] head_word;

    assign cfg_ok        = (samples_per_chirp_i != '0) && (chirp_num_i != '0);
    assign restart_state = (cfg_skip != '0) ? SKIP : CAPTURE;

    // Next-state and counter updates; dropping enable overrides everything else.
    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        chirp_cnt_nxt  = chirp_cnt;
        skip_cnt_nxt   = skip_cnt;
        latch_cfg      = 1'b0;
        push           = 1'b0;
        last_flag      = 1'b0;
        flush          = 1'b0;
        set_cfg_err    = 1'b0;
        set_chirp_err  = 1'b0;

        if (state != IDLE && !enable_i) begin
            state_nxt      = IDLE;
            sample_cnt_nxt = '0;
            chirp_cnt_nxt  = '0;
            skip_cnt_nxt   = '0;
            flush          = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        if (cfg_ok) begin
                            state_nxt     = WAIT_CHIRP;
                            latch_cfg     = 1'b1;
                            chirp_cnt_nxt = '0;
                        end else begin
                            set_cfg_err = 1'b1;
                        end
                    end
                end
                WAIT_CHIRP: begin
                    if (chirp_start_i) begin
                        state_nxt      = restart_state;
                        sample_cnt_nxt = '0;
                        skip_cnt_nxt   = '0;
                    end
                end
                SKIP: begin
                    if (chirp_start_i) begin
                        set_chirp_err  = 1'b1;
                        state_nxt      = restart_state;
                        sample_cnt_nxt = '0;
                        skip_cnt_nxt   = '0;
                    end else if (adc_valid_i) begin
                        if (skip_cnt == cfg_skip - SKIP_W'(1)) begin
                            state_nxt    = CAPTURE;
                            skip_cnt_nxt = '0;
                        end else begin
                            skip_cnt_nxt = skip_cnt + SKIP_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (chirp_start_i) begin
                        set_chirp_err  = 1'b1;
                        state_nxt      = restart_state;
                        sample_cnt_nxt = '0;
                        skip_cnt_nxt   = '0;
                    end else if (adc_valid_i) begin
                        push = 1'b1;
                        if (sample_cnt == cfg_n - SAMPLE_IDX_W'(1)) begin
                            sample_cnt_nxt = '0;
                            if (chirp_cnt == cfg_m - CHIRP_IDX_W'(1)) begin
                                last_flag = 1'b1;
                                state_nxt = FRAME_DONE;
                            end else begin
                                chirp_cnt_nxt = chirp_cnt + CHIRP_IDX_W'(1);
                                state_nxt     = WAIT_CHIRP;
                            end
                        end else begin
                            sample_cnt_nxt = sample_cnt + SAMPLE_IDX_W'(1);
                        end
                    end
                end
                FRAME_DONE: begin
                    if (cfg_ok) begin
                        state_nxt     = WAIT_CHIRP;
                        latch_cfg     = 1'b1;
                        chirp_cnt_nxt = '0;
                    end else begin
                        state_nxt   = IDLE;
                        set_cfg_err = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A sample is lost only if the buffer is full and nothing drains this cycle.
    assign fifo_pop    = ~fifo_empty & sample_ready_i;
    assign set_overrun = push & fifo_full & ~fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            chirp_cnt  <= '0;
            skip_cnt   <= '0;
            cfg_n      <= '0;
            cfg_m      <= '0;
            cfg_skip   <= '0;
            overrun_o  <= 1'b0;
            chirp_err_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= sample_cnt_nxt;
            chirp_cnt  <= chirp_cnt_nxt;
            skip_cnt   <= skip_cnt_nxt;
            if (latch_cfg) begin
                cfg_n    <= samples_per_chirp_i;
                cfg_m    <= chirp_num_i;
                cfg_skip <= skip_samples_i;
            end
            overrun_o   <= set_overrun   | (overrun_o   & ~clear_flags_i);
            chirp_err_o <= set_chirp_err | (chirp_err_o & ~clear_flags_i);
            cfg_err_o   <= set_cfg_err   | (cfg_err_o   & ~clear_flags_i);
        end
    end

    assign push_word = {adc_data_i, sample_cnt, chirp_cnt, last_flag};

    sample_fifo_2 #(
        .WIDTH(PAYLOAD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .data_i  (push_word),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sample_valid_o = ~fifo_empty;
    assign {sample_o, sample_idx_o, chirp_idx_o, last_sample_o} =
        sample_valid_o ? head_word : '0;
    assign frame_done_o = (state == FRAME_DONE);
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_adc_chirp_capture.sv
// Self-checking bench for adc_chirp_capture: directed scenarios plus random
// frames compared against a transaction-level model of the captured stream.
`timescale 1ns/1ps
module tb_adc_chirp_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        chirp_start_i;
    logic [11:0] adc_data_i;
    logic        adc_valid_i;
    logic [9:0]  samples_per_chirp_i;
    logic [4:0]  chirp_num_i;
    logic [7:0]  skip_samples_i;
    logic        clear_flags_i;
    logic        sample_ready_i;
    logic [11:0] sample_o;
    logic        sample_valid_o;
    logic [9:0]  sample_idx_o;
    logic [4:0]  chirp_idx_o;
    logic        last_sample_o;
    logic        frame_done_o;
    logic        busy_o;
    logic        overrun_o;
    logic        chirp_err_o;
    logic        cfg_err_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int fd_cnt     = 0;
    int fd0;
    logic [27:0] got_q [$];
    logic [27:0] exp_q [$];
    logic [11:0] d0, d1, d3;

    always #5 clk = ~clk;

    adc_chirp_capture dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .chirp_start_i       (chirp_start_i),
        .adc_data_i          (adc_data_i),
        .adc_valid_i         (adc_valid_i),
        .samples_per_chirp_i (samples_per_chirp_i),
        .chirp_num_i         (chirp_num_i),
        .skip_samples_i      (skip_samples_i),
        .clear_flags_i       (clear_flags_i),
        .sample_ready_i      (sample_ready_i),
        .sample_o            (sample_o),
        .sample_valid_o      (sample_valid_o),
        .sample_idx_o        (sample_idx_o),
        .chirp_idx_o         (chirp_idx_o),
        .last_sample_o       (last_sample_o),
        .frame_done_o        (frame_done_o),
        .busy_o              (busy_o),
        .overrun_o           (overrun_o),
        .chirp_err_o         (chirp_err_o),
        .cfg_err_o           (cfg_err_o)
    );

    // Collect every accepted output word and count frame-done pulses.
    always @(negedge clk) begin
        if (sample_valid_o && sample_ready_i)
            got_q.push_back({sample_o, sample_idx_o, chirp_idx_o, last_sample_o});
        if (frame_done_o)
            fd_cnt++;
    end

    function automatic logic [27:0] model_word(logic [11:0] d, int s, int c, int n, int m);
        logic last;
        last = (c == m - 1) && (s == n - 1);
        return {d, s[9:0], c[4:0], last};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic av, input logic [11:0] d);
        chirp_start_i = cs;
        adc_valid_i   = av;
        adc_data_i    = d;
        tick();
        chirp_start_i = 1'b0;
        adc_valid_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 12'h000);
    endtask

    // One chirp: start pulse, skip settling strobes, then n captured strobes.
    task automatic run_chirp(input int c, input int n, input int m, input int skip,
                             input int max_gap);
        logic [11:0] d;
        applyStimulus(1'b1, 1'b0, 12'h000);
        for (int s = 0; s < skip + n; s++) begin
            d = 12'($urandom_range(0, 4095));
            applyStimulus(1'b0, 1'b1, d);
            if (s >= skip)
                exp_q.push_back(model_word(d, s - skip, c, n, m));
            idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic compare_queues(input string tag);
        int k;
        checkOutput({tag, " count"}, got_q.size(), exp_q.size());
        k = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < k; i++)
            checkOutput($sformatf("%s word[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " sample_o"}, 32'(sample_o), 0);
        checkOutput({tag, " sample_valid_o"}, 32'(sample_valid_o), 0);
        checkOutput({tag, " sample_idx_o"}, 32'(sample_idx_o), 0);
        checkOutput({tag, " chirp_idx_o"}, 32'(chirp_idx_o), 0);
        checkOutput({tag, " last_sample_o"}, 32'(last_sample_o), 0);
        checkOutput({tag, " frame_done_o"}, 32'(frame_done_o), 0);
        checkOutput({tag, " busy_o"}, 32'(busy_o), 0);
        checkOutput({tag, " overrun_o"}, 32'(overrun_o), 0);
        checkOutput({tag, " chirp_err_o"}, 32'(chirp_err_o), 0);
        checkOutput({tag, " cfg_err_o"}, 32'(cfg_err_o), 0);
    endtask

    task automatic configure(input int n, input int m, input int skip);
        samples_per_chirp_i = 10'(n);
        chirp_num_i         = 5'(m);
        skip_samples_i      = 8'(skip);
    endtask

    task automatic stop_session();
        enable_i = 1'b0;
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        enable_i = 1'b0;
        chirp_start_i = 1'b0;
        adc_data_i = '0;
        adc_valid_i = 1'b0;
        clear_flags_i = 1'b0;
        sample_ready_i = 1'b0;
        configure(0, 0, 0);
        idle(2);
        check_all_zero("reset");
        rst = 1'b0;
        idle(1);

        // N=4, M=2, skip=2 with a ready consumer
        configure(4, 2, 2);
        sample_ready_i = 1'b1;
        enable_i = 1'b1;
        idle(1);
        checkOutput("A busy", 32'(busy_o), 1);
        fd0 = fd_cnt;
        run_chirp(0, 4, 2, 2, 1);
        run_chirp(1, 4, 2, 2, 1);
        idle(3);
        checkOutput("A frame_done count", fd_cnt - fd0, 1);
        compare_queues("A");
        checkOutput("A chirp_err", 32'(chirp_err_o), 0);
        checkOutput("A overrun", 32'(overrun_o), 0);
        stop_session();
        checkOutput("A busy after disable", 32'(busy_o), 0);

        // skip=0, N=3, M=1: one-cycle latency and same-cycle start/valid
        configure(3, 1, 0);
        enable_i = 1'b1;
        idle(1);
        fd0 = fd_cnt;
        applyStimulus(1'b1, 1'b1, 12'hAAA);
        checkOutput("B same-cycle not captured", 32'(sample_valid_o), 0);
        d0 = 12'($urandom_range(0, 4095));
        applyStimulus(1'b0, 1'b1, d0);
        exp_q.push_back(model_word(d0, 0, 0, 3, 1));
        checkOutput("B first valid", 32'(sample_valid_o), 1);
        checkOutput("B first idx", 32'(sample_idx_o), 0);
        checkOutput("B first data", 32'(sample_o), 32'(d0));
        for (int s = 1; s < 3; s++) begin
            idle(1);
            d1 = 12'($urandom_range(0, 4095));
            applyStimulus(1'b0, 1'b1, d1);
            exp_q.push_back(model_word(d1, s, 0, 3, 1));
        end
        checkOutput("B frame_done after 3rd", 32'(frame_done_o), 1);
        idle(2);
        checkOutput("B frame_done count", fd_cnt - fd0, 1);
        compare_queues("B");
        stop_session();

        // Stalled consumer: third sample dropped, overrun sticky until cleared
        configure(4, 1, 0);
        sample_ready_i = 1'b0;
        enable_i = 1'b1;
        idle(1);
        applyStimulus(1'b1, 1'b0, 12'h000);
        d0 = 12'($urandom_range(0, 4095));
        d1 = 12'($urandom_range(0, 4095));
        applyStimulus(1'b0, 1'b1, d0);
        idle(1);
        applyStimulus(1'b0, 1'b1, d1);
        idle(1);
        applyStimulus(1'b0, 1'b1, 12'h5A5);
        idle(1);
        checkOutput("C overrun set", 32'(overrun_o), 1);
        checkOutput("C head data", 32'(sample_o), 32'(d0));
        checkOutput("C head idx", 32'(sample_idx_o), 0);
        sample_ready_i = 1'b1;
        idle(1);
        checkOutput("C second data", 32'(sample_o), 32'(d1));
        checkOutput("C second idx", 32'(sample_idx_o), 1);
        idle(1);
        checkOutput("C drained", 32'(sample_valid_o), 0);
        d3 = 12'($urandom_range(0, 4095));
        applyStimulus(1'b0, 1'b1, d3);
        idle(2);
        exp_q.push_back(model_word(d0, 0, 0, 4, 1));
        exp_q.push_back(model_word(d1, 1, 0, 4, 1));
        exp_q.push_back(model_word(d3, 3, 0, 4, 1));
        checkOutput("C overrun still sticky", 32'(overrun_o), 1);
        clear_flags_i = 1'b1;
        idle(1);
        clear_flags_i = 1'b0;
        checkOutput("C overrun cleared", 32'(overrun_o), 0);
        compare_queues("C");
        stop_session();

        // chirp_start mid-capture restarts the same chirp index
        configure(4, 2, 1);
        enable_i = 1'b1;
        idle(1);
        fd0 = fd_cnt;
        applyStimulus(1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 12'h111);
        idle(1);
        for (int s = 0; s < 2; s++) begin
            d0 = 12'($urandom_range(0, 4095));
            applyStimulus(1'b0, 1'b1, d0);
            exp_q.push_back(model_word(d0, s, 0, 4, 2));
            idle(1);
        end
        checkOutput("D no error yet", 32'(chirp_err_o), 0);
        run_chirp(0, 4, 2, 1, 1);
        checkOutput("D chirp_err set", 32'(chirp_err_o), 1);
        run_chirp(1, 4, 2, 1, 1);
        idle(3);
        checkOutput("D frame_done count", fd_cnt - fd0, 1);
        compare_queues("D");
        clear_flags_i = 1'b1;
        idle(1);
        clear_flags_i = 1'b0;
        checkOutput("D chirp_err cleared", 32'(chirp_err_o), 0);
        stop_session();

        // Abort mid-capture: buffer flushed, no frame_done
        configure(4, 1, 0);
        sample_ready_i = 1'b0;
        enable_i = 1'b1;
        idle(1);
        fd0 = fd_cnt;
        applyStimulus(1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 12'h123);
        idle(1);
        applyStimulus(1'b0, 1'b1, 12'h456);
        idle(1);
        checkOutput("E held before abort", 32'(sample_valid_o), 1);
        enable_i = 1'b0;
        idle(1);
        checkOutput("E valid after abort", 32'(sample_valid_o), 0);
        checkOutput("E busy after abort", 32'(busy_o), 0);
        checkOutput("E frame_done after abort", 32'(frame_done_o), 0);
        sample_ready_i = 1'b1;
        idle(3);
        checkOutput("E no frame_done pulse", fd_cnt - fd0, 0);
        compare_queues("E");

        // Zero chirp count: stay idle with cfg_err, then reset clears it
        configure(4, 0, 2);
        enable_i = 1'b1;
        idle(2);
        checkOutput("F busy", 32'(busy_o), 0);
        checkOutput("F cfg_err", 32'(cfg_err_o), 1);
        rst = 1'b1;
        idle(1);
        check_all_zero("F reset");
        rst = 1'b0;
        enable_i = 1'b0;
        idle(1);

        // Random frame shapes with random strobe spacing
        for (int it = 0; it < 4; it++) begin
            int n, m, skip;
            n    = $urandom_range(1, 5);
            m    = $urandom_range(1, 3);
            skip = $urandom_range(0, 3);
            configure(n, m, skip);
            sample_ready_i = 1'b1;
            enable_i = 1'b1;
            idle(1);
            fd0 = fd_cnt;
            for (int c = 0; c < m; c++)
                run_chirp(c, n, m, skip, 2);
            idle(3);
            checkOutput($sformatf("R%0d frame_done count", it), fd_cnt - fd0, 1);
            compare_queues($sformatf("R%0d", it));
            checkOutput($sformatf("R%0d overrun", it), 32'(overrun_o), 0);
            checkOutput($sformatf("R%0d chirp_err", it), 32'(chirp_err_o), 0);
            stop_session();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
